// File: rtl/uart_rx_control.sv
// uart_rx_control: 8N1 UART receiver with its own baud timing.
// Frames are MSB first. Each byte is sampled at mid-bit and reported
// with a one-cycle done strobe. A low stop bit gives a one-cycle error strobe.
module uart_rx_control #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_done_signal,
    output logic       rx_frame_error,
    output logic       rx_busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [15:0] HalfLast = 16'(HALF_BIT - 1);
    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStartBit,
        StDataBit,
        StStopBit
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic rx_meta, rx_s, rx_s_d;
    logic start_edge;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // A held-low line never looks like a new start; only a fresh 1->0 does
    assign start_edge = !rx_s && rx_s_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state, bit timing and sampling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (start_edge) begin
                    state_d = StStartBit;
                end
            end

            StStartBit: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        // Start bit gone by mid-bit: treat as a glitch
                        state_d = StIdle;
                    end else begin
                        bit_idx_d = 3'd0;
                        state_d   = StDataBit;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StDataBit: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = 16'd0;
                    shift_d = {shift_q[6:0], rx_s};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStopBit;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StStopBit: begin
                if (cnt_q == BitLast) begin
                    // Leave in mid stop bit so a back-to-back start edge is caught
                    cnt_d   = 16'd0;
                    state_d = StIdle;
                    if (rx_s) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = 16'd0;
            end
        endcase
    end

    assign rx_data        = data_q;
    assign rx_done_signal = done_q;
    assign rx_frame_error = err_q;
    assign rx_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_control.sv
// Self-checking bench for uart_rx_control with a byte scoreboard.
module tb_uart_rx_control;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_done_signal;
    logic       rx_frame_error;
    logic       rx_busy;

    uart_rx_control #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_in          (rx_in),
        .rx_data        (rx_data),
        .rx_done_signal (rx_done_signal),
        .rx_frame_error (rx_frame_error),
        .rx_busy        (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb_q[$];

    int cyc           = 0;
    int done_cnt      = 0;
    int err_cnt       = 0;
    int busy_rises    = 0;
    int busy_rise_cyc = 0;
    int prev_done_cyc = 0;
    int last_lat      = 0;
    int last_gap      = 0;
    logic busy_prev   = 1'b0;
    logic pulse_prev  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on each done pulse
    always @(negedge clk) begin
        if (rst) begin
            busy_prev  = 1'b0;
            pulse_prev = 1'b0;
        end else begin
            if (rx_busy && !busy_prev) begin
                busy_rises++;
                busy_rise_cyc = cyc;
            end
            busy_prev = rx_busy;
            if (rx_done_signal || rx_frame_error) begin
                check("pulse_exclusive", 32'(rx_done_signal & rx_frame_error), 0);
                check("busy_low_at_pulse", 32'(rx_busy), 0);
                check("no_consecutive_pulse", 32'(pulse_prev), 0);
            end
            pulse_prev = rx_done_signal | rx_frame_error;
            if (rx_done_signal) begin
                done_cnt++;
                last_lat      = cyc - busy_rise_cyc;
                last_gap      = cyc - prev_done_cyc;
                prev_done_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
                end
            end
            if (rx_frame_error) err_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) sb_q.push_back(b);
        drive_bit(1'b0, CPB);
        for (int i = 7; i >= 0; i--) drive_bit(b[i], CPB);
        drive_bit(stop, CPB);
    endtask

    int snap_done, snap_err, snap_rises;

    initial begin
        rx_in = 1'b1;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_done", 32'(rx_done_signal), 0);
        check("reset_error", 32'(rx_frame_error), 0);
        check("reset_busy", 32'(rx_busy), 0);
        drive_bit(1'b1, 10);

        // Single frame 0xA5 and its latency from START_BIT entry
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 20);
        check("a5_done_count", 32'(done_cnt), 1);
        check("a5_no_error", 32'(err_cnt), 0);
        check("a5_latency_in_window", 32'(last_lat >= 151 && last_lat <= 153), 1);
        check("a5_rx_data_held", 32'(rx_data), 32'hA5);

        // Back-to-back 0x00 then 0xFF, no idle between
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1, 20);
        check("b2b_done_count", 32'(done_cnt), 3);
        check("b2b_gap", 32'(last_gap), 160);
        check("b2b_rx_data", 32'(rx_data), 32'hFF);

        // Short low glitch: busy blips, nothing reported
        snap_rises = busy_rises;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        check("glitch_busy_rise", 32'(busy_rises - snap_rises), 1);
        check("glitch_busy_low", 32'(rx_busy), 0);
        check("glitch_no_done", 32'(done_cnt), 3);
        check("glitch_no_error", 32'(err_cnt), 0);
        check("glitch_rx_data", 32'(rx_data), 32'hFF);

        // Bad stop bit, then line held low (break), then a good frame
        send_frame(8'h3C, 1'b0);
        check("ferr_error_count", 32'(err_cnt), 1);
        check("ferr_no_done", 32'(done_cnt), 3);
        check("ferr_rx_data_kept", 32'(rx_data), 32'hFF);
        snap_rises = busy_rises;
        drive_bit(1'b0, 40);
        check("break_no_retrigger", 32'(busy_rises - snap_rises), 0);
        check("break_busy_low", 32'(rx_busy), 0);
        drive_bit(1'b1, 20);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 20);
        check("after_break_done", 32'(done_cnt), 4);
        check("after_break_rx_data", 32'(rx_data), 32'h81);

        // Reset during data bit 4 of 0xFF
        snap_done = done_cnt;
        snap_err  = err_cnt;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
        drive_bit(1'b1, 8);
        check("pre_reset_busy", 32'(rx_busy), 1);
        rst = 1'b1;
        #1;
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_done", 32'(rx_done_signal), 0);
        check("midreset_error", 32'(rx_frame_error), 0);
        check("midreset_busy", 32'(rx_busy), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bit(1'b1, 40);
        check("abort_no_done", 32'(done_cnt - snap_done), 0);
        check("abort_no_error", 32'(err_cnt - snap_err), 0);
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, 20);
        check("post_reset_rx_data", 32'(rx_data), 32'h5A);

        check("total_done", 32'(done_cnt), 5);
        check("total_error", 32'(err_cnt), 1);
        check("scoreboard_empty", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_control.md
# uart_rx_control

Receive-side UART framer and the counterpart of the transmit controller in the UART block. It deserialises 8N1 frames (one start bit, 8 data bits sent MSB first, one stop bit) from the serial line and presents each byte with a one-cycle done strobe. It also reports framing errors. It contains its own baud timing and mid-bit sampling, so it needs no external baud-clock strobes.

## Interface
Parameters:
- CLKS_PER_BIT, 868, system clocks per bit period (100 MHz / 115200); legal range 4..65535.
- HALF_BIT (localparam), CLKS_PER_BIT/2 (integer divide), offset from the start edge to the mid-bit sample.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- rx_in  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  last correctly framed byte; bit 7 is the first data bit received.
- rx_done_signal  output  1  one-cycle pulse when rx_data has just been updated.
- rx_frame_error  output  1  one-cycle pulse when the stop bit sampled low.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Input synchroniser: two flops, rx_meta then rx_s, both reset to 1. A third flop, rx_s_d (reset 1), holds the previous rx_s. Start edge = rx_s==0 && rx_s_d==1.
- Bit counter cnt: 16 bits, reset 0. bit_idx: 3 bits. shift_reg: 8 bits.
- FSM states: IDLE, START_BIT, DATA_BIT, STOP_BIT.
  - IDLE: on start edge, go to START_BIT with cnt=0. Otherwise stay.
  - START_BIT: cnt increments each clock. At cnt==HALF_BIT-1, sample rx_s.
    - If 1 (glitch): go to IDLE with no pulse.
    - If 0: set cnt=0, bit_idx=0, go to DATA_BIT.
  - DATA_BIT: cnt increments. At cnt==CLKS_PER_BIT-1:
    - shift_reg <= {shift_reg[6:0], rx_s}; cnt=0.
    - If bit_idx==7, go to STOP_BIT; else bit_idx+1.
  - STOP_BIT: at cnt==CLKS_PER_BIT-1, sample rx_s and go to IDLE (mid stop bit).
    - If 1: rx_data <= shift_reg and rx_done_signal=1 for one clock.
    - If 0: rx_frame_error=1 for one clock; rx_data unchanged.
  - Undefined state encodings go to IDLE.
- Return to IDLE in mid stop bit allows back-to-back frames with zero idle time.
- A new frame always requires a fresh 1->0 transition. A line held low (break) never retriggers until it returns high.
- rx_done_signal and rx_frame_error are mutually exclusive and never asserted for two consecutive cycles.

## Timing
- Reset values: rx_data=8'h00, rx_done_signal=0, rx_frame_error=0, rx_busy=0, state IDLE, cnt=0, synchroniser flops=1.
- Reset mid-frame aborts immediately. The partial byte is discarded and no pulse is issued.
- Start detection: state is START_BIT 3 clocks after the first rising edge at which rx_in is low (2 synchroniser stages plus the state register).
- Data sample points sit at HALF_BIT + n*CLKS_PER_BIT clocks after START_BIT entry, for n=1..8. The stop sample is at n=9.
- rx_done_signal / rx_frame_error assert on the clock following the stop sample: HALF_BIT + 9*CLKS_PER_BIT clocks after START_BIT entry.
- rx_data is stable from the done pulse until the next done pulse.
- rx_busy is registered: high from START_BIT entry, low in the same cycle the done or error pulse rises.
- Tolerance: sampling at mid-bit tolerates about ±4% baud mismatch over a frame.

## Test plan
All scenarios use CLKS_PER_BIT=16, with bits driven 16 clocks each.
- Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> exactly one done pulse, rx_data=8'hA5, no error. The pulse arrives 8+144 clocks (±1) after START_BIT entry.
- Back-to-back 0x00 then 0xFF with no idle between frames -> two done pulses 160 clocks apart; rx_data=8'h00, then 8'hFF.
- rx_in low for 4 clocks only -> rx_busy pulses high, returns to IDLE; no done, no error; rx_data unchanged.
- Frame 0x3C with stop bit 0, line then low 40 clocks, then high, then frame 0x81:
  - bad frame -> one frame_error pulse, no done, rx_data keeps the prior value;
  - no retrigger while the line stays low;
  - 0x81 is then received with a done pulse.
- rst asserted for 3 clocks during data bit 4 of frame 0xFF:
  - outputs immediately read rx_data=0, done=0, error=0, busy=0;
  - no pulse from the aborted frame;
  - a following frame 0x5A gives rx_data=8'h5A.
